// File: rtl/mode_select_if.sv
// Mode selector bus: raw push button in,
// registered mode byte, index and change strobe out.
interface mode_select_if;
  logic       button_n;
  logic [7:0] mode_out;
  logic [1:0] mode_index;
  logic       mode_strobe;

  modport master (
    input  button_n,
    output mode_out,
    output mode_index,
    output mode_strobe
  );

  modport slave (
    output button_n,
    input  mode_out,
    input  mode_index,
    input  mode_strobe
  );
endinterface

// File: rtl/mode_select.sv
// Push-button mode selector: sync, debounce, short/long
// press classification driving the video_config mode byte.
`ifndef MODE_VGA
`define MODE_VGA 8'h00
`endif
`ifndef MODE_720p
`define MODE_720p 8'h01
`endif
`ifndef MODE_1080p
`define MODE_1080p 8'h02
`endif

module mode_select #(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 50000000
) (
  input logic           clock,
  input logic           reset_n,
  mode_select_if.master bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST =
    DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX =
    HW'(LONG_PRESS_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HELD
  } state_t;

  state_t        state;
  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  logic [1:0]    idx;
  logic [1:0]    next_idx;
  logic          act;

  function automatic logic [7:0] mode_byte(
    input logic [1:0] i
  );
    case (i)
      2'd1:    return `MODE_720p;
      2'd2:    return `MODE_1080p;
      default: return `MODE_VGA;
    endcase
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      db_cnt <= '0;
    end else begin
      sync1 <= bus.button_n;
      sync2 <= sync1;
      if (sync2 == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        stable <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Long threshold is tested before release so it wins a tie.
  always_comb begin
    act      = 1'b0;
    next_idx = idx;
    if (state == PRESSED) begin
      if (hold_cnt == HOLD_LAST) begin
        act      = 1'b1;
        next_idx = 2'd0;
      end else if (stable) begin
        act      = 1'b1;
        next_idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      hold_cnt        <= '0;
      idx             <= 2'd0;
      bus.mode_out    <= `MODE_VGA;
      bus.mode_strobe <= 1'b0;
    end else begin
      bus.mode_strobe <= 1'b0;
      if (act) begin
        idx             <= next_idx;
        bus.mode_out    <= mode_byte(next_idx);
        bus.mode_strobe <= (next_idx != idx);
      end
      unique case (state)
        IDLE: begin
          if (!stable) begin
            state    <= PRESSED;
            hold_cnt <= '0;
          end
        end
        PRESSED: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= LONG_HELD;
          end else if (stable) begin
            state <= IDLE;
          end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        LONG_HELD: begin
          if (stable) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mode_index = idx;

endmodule

// File: tb/tb_mode_select.sv
// Bench for mode_select: random button stimulus
// against a press-level reference model.
`ifndef MODE_VGA
`define MODE_VGA 8'h00
`endif
`ifndef MODE_720p
`define MODE_720p 8'h01
`endif
`ifndef MODE_1080p
`define MODE_1080p 8'h02
`endif

module tb_mode_select;
  localparam int D = 4;
  localparam int L = 20;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int errors = 0;
  int checks = 0;

  mode_select_if bus();

  mode_select #(
    .DEBOUNCE_CYCLES(D),
    .LONG_PRESS_CYCLES(L)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] mode_byte(input int i);
    case (i)
      1:       return `MODE_720p;
      2:       return `MODE_1080p;
      default: return `MODE_VGA;
    endcase
  endfunction

  // Reference: button seen two edges late, level accepted
  // after D consecutive differing samples, then the press
  // is classified by how many cycles it has been held.
  logic m_h0 = 1'b1;
  logic m_h1 = 1'b1;
  logic m_stable = 1'b1;
  int   m_run = 0;
  int   m_phase = 0;
  int   m_age = 0;
  int   m_idx = 0;
  logic m_strobe = 1'b0;

  always @(posedge clock or negedge reset_n) begin : model
    logic s2p;
    logic st;
    int   nidx;
    bit   act;
    if (!reset_n) begin
      m_h0 = 1'b1;
      m_h1 = 1'b1;
      m_stable = 1'b1;
      m_run = 0;
      m_phase = 0;
      m_age = 0;
      m_idx = 0;
      m_strobe = 1'b0;
    end else begin
      s2p = m_h0;
      st = m_stable;
      m_h0 = m_h1;
      m_h1 = bus.button_n;
      if (s2p == m_stable) m_run = 0;
      else begin
        m_run++;
        if (m_run == D) begin
          m_stable = s2p;
          m_run = 0;
        end
      end
      act = 0;
      nidx = m_idx;
      if (m_phase == 0) begin
        if (!st) begin
          m_phase = 1;
          m_age = 0;
        end
      end else if (m_phase == 1) begin
        if (m_age == L - 1) begin
          act = 1;
          nidx = 0;
          m_phase = 2;
        end else if (st) begin
          act = 1;
          nidx = (m_idx + 1) % 3;
          m_phase = 0;
        end else m_age++;
      end else if (st) m_phase = 0;
      m_strobe = act && (nidx != m_idx);
      m_idx = nidx;
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      bus.button_n = 1'($urandom_range(0, 1));
      checks++;
      if (bus.mode_index !== 2'd0 ||
          bus.mode_out !== `MODE_VGA ||
          bus.mode_strobe !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: idx=%0d out=%h stb=%b",
          bus.mode_index, bus.mode_out, bus.mode_strobe);
      end
    end
    bus.button_n = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      checks++;
      if (bus.mode_index !== 2'd0 ||
          bus.mode_out !== `MODE_VGA ||
          bus.mode_strobe !== 1'b0) begin
        errors++;
        $display("FAIL reset_after: idx=%0d out=%h stb=%b",
          bus.mode_index, bus.mode_out, bus.mode_strobe);
      end
    end
  endtask

  task automatic test_short();
    int want[3] = '{1, 2, 0};
    int hold;
    int nstb;
    for (int p = 0; p < 3; p++) begin
      hold = $urandom_range(8, 12);
      nstb = 0;
      for (int i = 0; i < hold + 14; i++) begin
        @(negedge clock);
        checks++;
        if (bus.mode_index !== 2'(m_idx) ||
            bus.mode_out !== mode_byte(m_idx) ||
            bus.mode_strobe !== m_strobe) begin
          errors++;
          $display("FAIL short_cyc: idx=%0d stb=%b exp %0d %b",
            bus.mode_index, bus.mode_strobe, m_idx, m_strobe);
        end
        if (bus.mode_strobe === 1'b1) nstb++;
        bus.button_n = (i < hold) ? 1'b0 : 1'b1;
      end
      checks++;
      if (nstb != 1 || bus.mode_index !== 2'(want[p]) ||
          bus.mode_out !== mode_byte(want[p])) begin
        errors++;
        $display("FAIL short_press%0d: idx=%0d out=%h n=%0d exp %0d %h 1",
          p, bus.mode_index, bus.mode_out, nstb,
          want[p], mode_byte(want[p]));
      end
    end
  endtask

  task automatic test_bounce();
    logic [1:0] start;
    int g;
    int nstb;
    start = bus.mode_index;
    nstb = 0;
    for (int k = 0; k < 6; k++) begin
      g = $urandom_range(1, 3);
      for (int i = 0; i < g + $urandom_range(6, 9); i++) begin
        @(negedge clock);
        checks++;
        if (bus.mode_index !== 2'(m_idx) ||
            bus.mode_strobe !== m_strobe) begin
          errors++;
          $display("FAIL bounce_cyc: idx=%0d stb=%b exp %0d %b",
            bus.mode_index, bus.mode_strobe, m_idx, m_strobe);
        end
        if (bus.mode_strobe === 1'b1) nstb++;
        bus.button_n = (i < g) ? 1'b0 : 1'b1;
      end
    end
    checks++;
    if (nstb != 0 || bus.mode_index !== start) begin
      errors++;
      $display("FAIL bounce: idx=%0d n=%0d exp %0d 0",
        bus.mode_index, nstb, start);
    end
  endtask

  task automatic test_long();
    int nstb;
    int at;
    for (int i = 0; i < 48; i++) begin
      @(negedge clock);
      checks++;
      if (bus.mode_index !== 2'(m_idx) ||
          bus.mode_strobe !== m_strobe) begin
        errors++;
        $display("FAIL long_pre: idx=%0d stb=%b exp %0d %b",
          bus.mode_index, bus.mode_strobe, m_idx, m_strobe);
      end
      bus.button_n = ((i % 24) < 10) ? 1'b0 : 1'b1;
    end
    checks++;
    if (bus.mode_index !== 2'd2) begin
      errors++;
      $display("FAIL long_setup: idx=%0d exp 2", bus.mode_index);
    end
    nstb = 0;
    at = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      checks++;
      if (bus.mode_index !== 2'(m_idx) ||
          bus.mode_out !== mode_byte(m_idx) ||
          bus.mode_strobe !== m_strobe) begin
        errors++;
        $display("FAIL long_cyc: idx=%0d stb=%b exp %0d %b",
          bus.mode_index, bus.mode_strobe, m_idx, m_strobe);
      end
      if (bus.mode_strobe === 1'b1) begin
        nstb++;
        at = i;
      end
      if (i == 39) begin
        checks++;
        if (bus.mode_index !== 2'd0 ||
            bus.mode_out !== `MODE_VGA) begin
          errors++;
          $display("FAIL long_held: idx=%0d out=%h exp 0 %h",
            bus.mode_index, bus.mode_out, `MODE_VGA);
        end
      end
      bus.button_n = (i < 40) ? 1'b0 : 1'b1;
    end
    checks++;
    if (nstb != 1 || at != 2 + D + 1 + L) begin
      errors++;
      $display("FAIL long_strobe: n=%0d at=%0d exp 1 %0d",
        nstb, at, 2 + D + 1 + L);
    end
  endtask

  task automatic test_long_vga();
    int nstb;
    nstb = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      checks++;
      if (bus.mode_index !== 2'(m_idx) ||
          bus.mode_strobe !== m_strobe) begin
        errors++;
        $display("FAIL vga_cyc: idx=%0d stb=%b exp %0d %b",
          bus.mode_index, bus.mode_strobe, m_idx, m_strobe);
      end
      if (bus.mode_strobe === 1'b1) nstb++;
      bus.button_n = (i < 40) ? 1'b0 : 1'b1;
    end
    checks++;
    if (nstb != 0 || bus.mode_out !== `MODE_VGA) begin
      errors++;
      $display("FAIL long_vga: out=%h n=%0d exp %h 0",
        bus.mode_out, nstb, `MODE_VGA);
    end
  endtask

  task automatic test_reset_mid();
    int nstb;
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      bus.button_n = (i < 10) ? 1'b0 : 1'b1;
    end
    checks++;
    if (bus.mode_index !== 2'd1) begin
      errors++;
      $display("FAIL mid_setup: idx=%0d exp 1", bus.mode_index);
    end
    nstb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      checks++;
      if (bus.mode_index !== 2'(m_idx) ||
          bus.mode_strobe !== m_strobe) begin
        errors++;
        $display("FAIL mid_cyc: idx=%0d stb=%b exp %0d %b",
          bus.mode_index, bus.mode_strobe, m_idx, m_strobe);
      end
      if (i > 16 && bus.mode_strobe === 1'b1) nstb++;
      if (i == 0) bus.button_n = 1'b0;
      if (i == 28) bus.button_n = 1'b1;
      if (i == 16) reset_n = 1'b1;
      if (i == 13) begin
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.mode_index !== 2'd0 ||
            bus.mode_out !== `MODE_VGA ||
            bus.mode_strobe !== 1'b0) begin
          errors++;
          $display("FAIL mid_reset: idx=%0d out=%h stb=%b",
            bus.mode_index, bus.mode_out, bus.mode_strobe);
        end
      end
    end
    checks++;
    if (nstb != 1 || bus.mode_index !== 2'd1) begin
      errors++;
      $display("FAIL mid_release: idx=%0d n=%0d exp 1 1",
        bus.mode_index, nstb);
    end
  endtask

  task automatic test_back_to_back();
    logic lv[$];
    int h;
    int gap;
    for (int p = 0; p < 8; p++) begin
      h = $urandom_range(1, 45);
      gap = $urandom_range(1, 15);
      repeat (h) lv.push_back(1'b0);
      repeat (gap) lv.push_back(1'b1);
    end
    repeat (30) lv.push_back(1'b1);
    foreach (lv[i]) begin
      @(negedge clock);
      checks++;
      if (bus.mode_index !== 2'(m_idx) ||
          bus.mode_out !== mode_byte(m_idx) ||
          bus.mode_strobe !== m_strobe) begin
        errors++;
        $display("FAIL b2b_cyc%0d: idx=%0d stb=%b exp %0d %b",
          i, bus.mode_index, bus.mode_strobe, m_idx, m_strobe);
      end
      bus.button_n = lv[i];
    end
  endtask

  initial begin
    bus.button_n = 1'b1;
    test_reset();
    test_short();
    test_bounce();
    test_long();
    test_long_vga();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
